lfsr_tpg: RTL and testbench



---
 rtl/lfsr_tpg.sv | 105 ++++++++++
 tb/tb_lfsr_tpg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_tpg.sv
// Fibonacci LFSR test pattern generator for the BIST datapath: loadable seed,
// pattern counter and a valid/ready handshake toward the flip-flop chain.
module lfsr_tpg #(
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH-1:0]   TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0]   SEED         = 8'h01,
    parameter int                 NUM_PATTERNS = 255,
    parameter int                 CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             ready,
    output logic [WIDTH-1:0] pattern,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    // state | meaning
    // IDLE  | after reset; seed may be loaded, waiting for start
    // RUN   | presenting patterns, advancing on each valid && ready
    // DONE  | run complete; outputs frozen until start or rst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] seed_fixed;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] lfsr_next;
    logic             in_run;
    logic             xfer;

    assign in_run     = (state == RUN);
    assign xfer       = in_run && ready;
    assign lfsr_next  = {pattern[WIDTH-2:0], ^(pattern & TAPS)};
    // The all-zero lock-up state is never allowed into the seed register.
    assign seed_fixed = (seed_in == '0) ? SEED : seed_in;
    assign seed_eff   = seed_load ? seed_fixed : seed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (xfer && (count == LAST_CNT)) ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // A start coinciding with seed_load launches the run from the new seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_reg <= SEED;
            pattern  <= SEED;
            count    <= '0;
        end else if (in_run) begin
            if (xfer) begin
                pattern <= lfsr_next;
                count   <= count + 1'b1;
            end
        end else begin
            if (seed_load) begin
                seed_reg <= seed_fixed;
            end
            if (start) begin
                pattern <= seed_eff;
                count   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_tpg.sv
// Self-checking bench for lfsr_tpg: directed steps with random back-pressure,
// compared every cycle against a transfer-level reference model.
module tb_lfsr_tpg;

    localparam int N = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       seed_load;
    logic [7:0] seed_in;
    logic       ready;
    logic [7:0] pattern;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] count;

    lfsr_tpg #(
        .WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_PATTERNS(N), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load),
        .seed_in(seed_in), .ready(ready), .pattern(pattern), .valid(valid),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model
    bit         m_run;
    bit         m_done;
    logic [7:0] m_seed;
    logic [7:0] m_pat;
    int         m_cnt;

    function automatic logic [7:0] nxt(input logic [7:0] p);
        int ones;
        int v;
        ones = $countones(p & 8'hB8);
        v = (int'(p) * 2 + (ones % 2)) % 256;
        return v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_seed = 8'h01; m_pat = 8'h01; m_cnt = 0; m_run = 0; m_done = 0;
        end else if (!m_run) begin
            if (seed_load) m_seed = (seed_in == 8'h00) ? 8'h01 : seed_in;
            if (start) begin
                m_pat = m_seed; m_cnt = 0; m_run = 1; m_done = 0;
            end
        end else if (ready) begin
            m_pat = nxt(m_pat);
            m_cnt++;
            if (m_cnt == N) begin
                m_run = 0; m_done = 1;
            end
        end
        #1;
        chk("pattern", pattern, m_pat);
        chk("valid", valid, m_run);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("count", count, m_cnt);
        start = 0;
        seed_load = 0;
    endtask

    task automatic run_until_done(input bit rand_ready);
        int guard = 0;
        while (m_run && guard < 2000) begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            guard++;
        end
        chk("run_timeout", m_run, 0);
    endtask

    logic [7:0] exp0 [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    bit         seen [256];
    int         ndist;
    int         k;
    logic [7:0] s;

    initial begin
        rst = 1; start = 0; seed_load = 0; seed_in = 0; ready = 0;
        repeat (5) step();
        chk("rst_pattern", pattern, 8'h01);
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        rst = 0;
        step();

        // default run, ready tied high
        start = 1; ready = 1;
        step();
        ndist = 0;
        k = 0;
        while (valid === 1'b1 && k < 300) begin
            if (k < 7) chk("seq_start", pattern, exp0[k]);
            if (!seen[pattern]) ndist++;
            seen[pattern] = 1;
            step();
            k++;
        end
        chk("end_done", done, 1);
        chk("end_count", count, 255);
        chk("end_valid", valid, 0);
        chk("distinct", ndist, 255);
        chk("zero_seen", seen[0], 0);

        // seed load in IDLE
        rst = 1; step(); rst = 0;
        seed_in = 8'hA5; seed_load = 1; step();
        start = 1; ready = 0; step();
        chk("seed_first", pattern, 8'hA5);
        ready = 1; step();
        chk("seed_second", pattern, nxt(8'hA5));
        run_until_done(1);

        // zero seed falls back, then back-pressure at 0x08
        seed_in = 8'h00; seed_load = 1; step();
        start = 1; ready = 0; step();
        chk("zero_seed_first", pattern, 8'h01);
        ready = 1;
        repeat (3) step();
        chk("bp_pre", pattern, 8'h08);
        ready = 0;
        repeat (3) begin
            step();
            chk("bp_hold", pattern, 8'h08);
            chk("bp_count", count, 3);
            chk("bp_valid", valid, 1);
        end
        ready = 1; step();
        chk("bp_resume", pattern, 8'h11);
        run_until_done(1);

        // random seed, ignored controls mid-run, restart from the same seed
        s = 8'($urandom_range(1, 255));
        seed_in = s; seed_load = 1; step();
        start = 1; ready = 0; step();
        chk("rand_seed_first", pattern, s);
        repeat (20) begin
            ready = 1'($urandom_range(0, 1));
            step();
        end
        start = 1; seed_load = 1; seed_in = 8'h3C; ready = 1;
        step();
        run_until_done(1);
        start = 1; ready = 0; step();
        chk("restart_pattern", pattern, s);
        chk("restart_count", count, 0);
        chk("restart_done", done, 0);
        run_until_done(1);

        // start and seed_load together
        seed_in = 8'h5A; seed_load = 1; start = 1; ready = 0; step();
        chk("same_cycle_seed", pattern, 8'h5A);

        // reset mid-run at count 10
        ready = 1;
        k = 0;
        while (count !== 8'd10 && k < 50) begin
            step();
            k++;
        end
        chk("reach_count10", count, 10);
        rst = 1; step(); rst = 0;
        chk("midrst_pattern", pattern, 8'h01);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        start = 1; ready = 0; step();
        chk("midrst_seed_reg", pattern, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
